// File: rtl/axi_burst_write_initiator.sv
// AXI4 write-channel burst initiator.
// Accepts one burst command at a time and drives AW and W independently.
// W data is an incrementing pattern that starts at the command seed.
// The B response is captured, and running transaction/error counters are kept.
module axi_burst_write_initiator #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [2:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
    input  logic [AXI_DATA_WIDTH-1:0] cmd_seed,

    output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
    output logic [1:0]                axi_aw_burst,
    output logic [2:0]                axi_aw_size,
    output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
    output logic [7:0]                axi_aw_len,
    output logic                      axi_aw_valid,
    input  logic                      axi_aw_ready,

    output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
    output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
    output logic                      axi_w_last,
    output logic                      axi_w_valid,
    input  logic                      axi_w_ready,

    input  logic [1:0]                axi_b_resp,
    input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
    input  logic                      axi_b_valid,
    output logic                      axi_b_ready,

    output logic                      busy,
    output logic                      done_valid,
    output logic [1:0]                done_resp,
    output logic                      done_id_err,
    output logic [15:0]               txn_count,
    output logic [15:0]               err_count
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR_DATA = 2'd1,
        S_WAIT_B    = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t                    state;
    logic [7:0]                beat_cnt;
    logic [AXI_DATA_WIDTH-1:0] seed_q;
    logic                      aw_done;
    logic                      w_done;

    logic                      aw_hs;
    logic                      w_hs;
    logic                      aw_done_nx;
    logic                      w_done_nx;
    logic [7:0]                beat_nx;

    // Handshake and channel-completion decode; AW and W finish in either order
    always_comb begin
        aw_hs      = axi_aw_valid & axi_aw_ready;
        w_hs       = axi_w_valid & axi_w_ready;
        aw_done_nx = aw_done | aw_hs;
        w_done_nx  = w_done | (w_hs & axi_w_last);
        beat_nx    = beat_cnt + 8'd1;
        cmd_ready  = (state == S_IDLE);
        axi_b_ready = (state == S_WAIT_B);
    end

    // Main sequencer: command capture, AW/W drive, B capture and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            beat_cnt     <= '0;
            seed_q       <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            axi_aw_addr  <= '0;
            axi_aw_burst <= '0;
            axi_aw_size  <= '0;
            axi_aw_id    <= '0;
            axi_aw_len   <= '0;
            axi_aw_valid <= 1'b0;
            axi_w_data   <= '0;
            axi_w_strb   <= '0;
            axi_w_last   <= 1'b0;
            axi_w_valid  <= 1'b0;
            busy         <= 1'b0;
            done_valid   <= 1'b0;
            done_resp    <= '0;
            done_id_err  <= 1'b0;
            txn_count    <= '0;
            err_count    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_valid <= 1'b0;
                    if (cmd_valid) begin
                        // The AW payload registers double as the latched command.
                        axi_aw_addr  <= cmd_addr;
                        axi_aw_burst <= cmd_burst;
                        axi_aw_size  <= cmd_size;
                        axi_aw_id    <= cmd_id;
                        axi_aw_len   <= cmd_len;
                        axi_aw_valid <= 1'b1;
                        seed_q       <= cmd_seed;
                        beat_cnt     <= '0;
                        axi_w_data   <= cmd_seed;
                        axi_w_strb   <= '1;
                        axi_w_last   <= (cmd_len == 8'd0);
                        axi_w_valid  <= 1'b1;
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_ADDR_DATA;
                    end
                end

                S_ADDR_DATA: begin
                    if (aw_hs) begin
                        axi_aw_valid <= 1'b0;
                        aw_done      <= 1'b1;
                    end
                    if (w_hs) begin
                        beat_cnt <= beat_nx;
                        if (axi_w_last) begin
                            axi_w_valid <= 1'b0;
                            axi_w_last  <= 1'b0;
                            w_done      <= 1'b1;
                        end else begin
                            axi_w_data <= seed_q + AXI_DATA_WIDTH'(beat_nx);
                            axi_w_last <= (beat_nx == axi_aw_len);
                        end
                    end
                    if (aw_done_nx && w_done_nx) begin
                        state <= S_WAIT_B;
                    end
                end

                S_WAIT_B: begin
                    if (axi_b_valid) begin
                        done_resp   <= axi_b_resp;
                        done_id_err <= (axi_b_id != axi_aw_id);
                        done_valid  <= 1'b1;
                        state       <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_valid <= 1'b0;
                    if (txn_count != 16'hFFFF) begin
                        txn_count <= txn_count + 16'd1;
                    end
                    if (((done_resp != 2'b00) || done_id_err) && (err_count != 16'hFFFF)) begin
                        err_count <= err_count + 16'd1;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
